// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the divider state encoding.
package alu_pkg;

  localparam int WORD_WIDTH = 32;

  // Divider FSM states; DIV_FIX is only entered when DIV_SIGNED_EN is defined.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage : alu_pkg

// File: rtl/divide_seq_div_step.sv
// div_step: one restoring-division step (shift-compare-subtract).
// Combinational; the only arithmetic of the divider lives here.
// Relies on the invariant rem < divisor (rem starts at 0, divisor != 0),
// so the partial remainder is below 2*divisor and the sign bit of the
// WIDTH+1 bit difference is exactly the "partial < divisor" borrow.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] partial_s;
  logic [WIDTH:0] diff_s;
  logic           borrow_s;

  assign partial_s = {rem, dividend_msb};
  assign diff_s    = partial_s - {1'b0, divisor};
  assign borrow_s  = diff_s[WIDTH];

  // Restore the partial remainder on borrow, otherwise keep the difference.
  always_comb begin
    next_rem = partial_s[WIDTH-1:0];
    q_bit    = 1'b0;
    if (borrow_s) begin
      next_rem = partial_s[WIDTH-1:0];
      q_bit    = 1'b0;
    end else begin
      next_rem = diff_s[WIDTH-1:0];
      q_bit    = 1'b1;
    end
  end

endmodule : div_step

// File: rtl/divide_seq.sv
// divide_seq: multi-cycle restoring divider with valid/ready handshakes.
// One quotient bit per clock; divide-by-zero short-circuits to DONE.
// Optional feature macro: DIV_SIGNED_EN adds the is_signed port, signed
// (truncating) division via magnitudes plus a FIX state for the sign
// correction, and the MIN / -1 overflow flag.
module divide_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int                 CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ZERO_VAL  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_VAL  = {WIDTH{1'b1}};

  div_state_t       state_r;
  logic [WIDTH-1:0] rem_r;        // running partial remainder
  logic [WIDTH-1:0] dvd_r;        // dividend shifts out MSB-first, quotient shifts in LSB
  logic [WIDTH-1:0] dsr_r;        // divisor magnitude
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] remo_r;
  logic             dbz_r;
  logic             ovf_r;

  logic [WIDTH-1:0] mag_dvd_s;
  logic [WIDTH-1:0] mag_dsr_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic neg_q_r;
  logic neg_r_r;
  logic ovf_pend_r;
`endif

  // Operand magnitudes presented to the unsigned core at acceptance.
  always_comb begin
    mag_dvd_s = dividend;
    mag_dsr_s = divisor;
`ifdef DIV_SIGNED_EN
    if (is_signed && dividend[WIDTH-1]) begin
      mag_dvd_s = ZERO_VAL - dividend;
    end else begin
      mag_dvd_s = dividend;
    end
    if (is_signed && divisor[WIDTH-1]) begin
      mag_dsr_s = ZERO_VAL - divisor;
    end else begin
      mag_dsr_s = divisor;
    end
`endif
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem          (rem_r),
    .dividend_msb (dvd_r[WIDTH-1]),
    .divisor      (dsr_r),
    .next_rem     (step_rem_s),
    .q_bit        (step_q_s)
  );

  // Divider FSM: operand capture, per-bit stepping, result hold and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= DIV_IDLE;
      rem_r       <= ZERO_VAL;
      dvd_r       <= ZERO_VAL;
      dsr_r       <= ZERO_VAL;
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quot_r      <= ZERO_VAL;
      remo_r      <= ZERO_VAL;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      ovf_pend_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (in_valid) begin
            cnt_r      <= {CNT_W{1'b0}};
            rem_r      <= ZERO_VAL;
            dvd_r      <= mag_dvd_s;
            dsr_r      <= mag_dsr_s;
            in_ready_r <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_r    <= is_signed & dividend[WIDTH-1];
            ovf_pend_r <= is_signed && (dividend == MIN_VAL) && (divisor == ONES_VAL);
`endif
            if (divisor == ZERO_VAL) begin
              // Result is known now; out_valid rises one edge later in DONE.
              quot_r  <= ONES_VAL;
              remo_r  <= dividend;
              dbz_r   <= 1'b1;
              ovf_r   <= 1'b0;
              state_r <= DIV_DONE;
            end else begin
              state_r <= DIV_RUN;
            end
          end
        end

        DIV_RUN: begin
          rem_r <= step_rem_s;
          dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_STEP) begin
`ifdef DIV_SIGNED_EN
            state_r <= DIV_FIX;
`else
            quot_r      <= {dvd_r[WIDTH-2:0], step_q_s};
            remo_r      <= step_rem_s;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DIV_DONE;
`endif
          end
        end

        DIV_FIX: begin
`ifdef DIV_SIGNED_EN
          // MIN / -1 needs no special case: |MIN| / 1 already yields MIN's bit pattern.
          quot_r      <= neg_q_r ? (ZERO_VAL - dvd_r) : dvd_r;
          remo_r      <= neg_r_r ? (ZERO_VAL - rem_r) : rem_r;
          dbz_r       <= 1'b0;
          ovf_r       <= ovf_pend_r;
          out_valid_r <= 1'b1;
          state_r     <= DIV_DONE;
`else
          state_r     <= DIV_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
`endif
        end

        DIV_DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= DIV_IDLE;
          end
        end

        default: begin
          state_r     <= DIV_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quot_r;
  assign remainder   = remo_r;
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

endmodule : divide_seq

// File: tb/tb_divide_seq.sv
// Self-checking bench for divide_seq: scoreboard of expected results
// pushed at operand acceptance and popped when out_valid appears.
module tb_divide_seq;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam int RUN_LAT = W + 1;
`else
  localparam int RUN_LAT = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;
`ifdef DIV_SIGNED_EN
  logic         is_signed;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  divide_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: computes the expected result independently of the DUT.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.q   = {W{1'b1}};
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.lat = RUN_LAT;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q   = 32'h8000_0000;
        e.r   = 32'h0;
        e.ovf = 1'b1;
      end else if (sgn) begin
        sa  = a;
        sb  = b;
        e.q = sa / sb;
        e.r = sa % sb;
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  // Issue one operation, check result against scoreboard, optionally stall the consumer.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input int hold);
    int   t;
    int   lat;
    exp_t e;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check_val("accept_ready", {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
`ifdef DIV_SIGNED_EN
    is_signed = sgn;
`endif
    sb_q.push_back(model(a, b, sgn));
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
`ifdef DIV_SIGNED_EN
    is_signed = ~sgn;
`endif
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_val("out_valid_seen", {63'd0, out_valid}, 64'd1);
    check_val("sb_nonempty", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("latency", 64'(lat), 64'(e.lat));
      check_val("quotient", {32'd0, quotient}, {32'd0, e.q});
      check_val("remainder", {32'd0, remainder}, {32'd0, e.r});
      check_val("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
      check_val("overflow", {63'd0, overflow}, {63'd0, e.ovf});
      check_val("in_ready_busy", {63'd0, in_ready}, 64'd0);
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        dividend = $urandom;
        divisor  = $urandom;
        @(posedge clk); #1;
        check_val("hold_valid", {63'd0, out_valid}, 64'd1);
        check_val("hold_ready", {63'd0, in_ready}, 64'd0);
        check_val("hold_q", {32'd0, quotient}, {32'd0, e.q});
        check_val("hold_r", {32'd0, remainder}, {32'd0, e.r});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("valid_drop", {63'd0, out_valid}, 64'd0);
      check_val("ready_back", {63'd0, in_ready}, 64'd1);
      check_val("q_kept", {32'd0, quotient}, {32'd0, e.q});
      check_val("r_kept", {32'd0, remainder}, {32'd0, e.r});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_q", {32'd0, quotient}, 64'd0);
    check_val("rst_r", {32'd0, remainder}, 64'd0);
    check_val("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check_val("rst_ovf", {63'd0, overflow}, 64'd0);

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'd5, 32'd9, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b0, 10);
    run_op(32'd0, 32'd12345, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 3);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom >> (k * 5);
      run_op(ra, rb, 1'b0, k % 2);
    end

    // Abort 40/3 at step 12 with a reset; no result may follow.
    dividend = 32'd40;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("abort_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("abort_no_result", 64'(seen), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, 0);

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 2);
`endif

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_divide_seq
